// File: rtl/if_stage_prefetch_pkg.sv
// if_stage_prefetch_pkg: shared widths, reset PC and the IF->ID payload layout
package if_stage_prefetch_pkg;
  localparam int IF_ID_LEN = 64;
  localparam int BR_BUS_LEN = 33;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/if_stage_prefetch_fetch_fifo.sv
// if_stage_prefetch_fetch_fifo: synchronous FIFO with flush, occupancy count and full/empty flags
module if_stage_prefetch_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + AW'(1);
  endfunction
  assign do_push = push_i & ~flush_i & (~full_o | pop_i);
  assign do_pop = pop_i & ~flush_i & ~empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  // Pointer and occupancy update; flush discards every entry at once
  always_comb begin
    wr_d = flush_i ? '0 : do_push ? inc(wr_q) : wr_q;
    rd_d = flush_i ? '0 : do_pop ? inc(rd_q) : rd_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // Control state registers
  always_ff @(posedge clk)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // Storage needs no reset; validity is tracked by the count
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch: decoupled IF stage with multiple in-flight fetches, instruction buffer and branch cancel
module if_stage_prefetch
  import if_stage_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IBUF_DEPTH = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BR_BUS_LEN-1:0] br_bus,
  input  logic                  ID_allowin,
  output logic                  IF_ID_valid,
  output logic [IF_ID_LEN-1:0]  IF_ID_bus,
  output logic                  inst_sram_req,
  output logic                  inst_sram_wr,
  output logic [1:0]            inst_sram_size,
  output logic [3:0]            inst_sram_wstrb,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic                  inst_sram_addr_ok,
  input  logic                  inst_sram_data_ok,
  input  logic [31:0]           inst_sram_rdata
);
  localparam int OW = $clog2(MAX_OUTST+2);
  localparam int QW = $clog2(MAX_OUTST+1);
  localparam int IW = $clog2(IBUF_DEPTH+1);
  logic br_taken;
  logic [31:0] br_target;
  logic [31:0] fetch_pc_q, fetch_pc_d, hold_addr_q, hold_addr_d;
  logic hold_q, hold_d;
  logic [OW-1:0] out_q, out_d, cancel_q, cancel_d;
  logic credit, hs, pend, drop;
  logic pcq_push, pcq_pop, pcq_full, pcq_empty;
  logic [31:0] pcq_head, resp_pc;
  logic [QW-1:0] pcq_cnt;
  logic ibuf_push, ibuf_pop, ibuf_full, ibuf_empty;
  logic [IW-1:0] ibuf_cnt;
  if_id_t ibuf_din;
  assign br_taken = br_bus[32];
  assign br_target = word_align(br_bus[31:0]);
  assign inst_sram_wr = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign credit = (out_q < OW'(MAX_OUTST)) && ((32'(out_q) + 32'(ibuf_cnt)) < 32'(IBUF_DEPTH));
  assign inst_sram_req = ~reset & (hold_q | credit);
  assign inst_sram_addr = hold_q ? hold_addr_q : fetch_pc_q;
  assign hs = inst_sram_req & inst_sram_addr_ok;
  assign pend = inst_sram_req & ~inst_sram_addr_ok;
  assign resp_pc = pcq_empty ? inst_sram_addr : pcq_head;
  assign pcq_push = hs & ~(pcq_empty & inst_sram_data_ok);
  assign pcq_pop = inst_sram_data_ok & ~pcq_empty;
  assign drop = br_taken | (cancel_q != '0);
  assign ibuf_push = inst_sram_data_ok & ~drop;
  assign ibuf_din = '{inst: inst_sram_rdata, pc: resp_pc};
  assign IF_ID_valid = ~ibuf_empty & ~br_taken;
  assign ibuf_pop = IF_ID_valid & ID_allowin;
  if_stage_prefetch_fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_pc_q (
    .clk(clk), .reset(reset), .push_i(pcq_push), .pop_i(pcq_pop), .flush_i(1'b0),
    .data_i(inst_sram_addr), .data_o(pcq_head), .count_o(pcq_cnt), .full_o(pcq_full), .empty_o(pcq_empty)
  );
  if_stage_prefetch_fetch_fifo #(.WIDTH(IF_ID_LEN), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk), .reset(reset), .push_i(ibuf_push), .pop_i(ibuf_pop), .flush_i(br_taken),
    .data_i(ibuf_din), .data_o(IF_ID_bus), .count_o(ibuf_cnt), .full_o(ibuf_full), .empty_o(ibuf_empty)
  );
  // On a branch every in-flight request plus a still-pending one becomes a cancel credit
  always_comb begin
    out_d = out_q + OW'(hs) - OW'(inst_sram_data_ok);
    cancel_d = br_taken ? out_d + OW'(pend) : cancel_q - OW'(inst_sram_data_ok && cancel_q != '0);
    hold_d = pend & (br_taken | hold_q);
    hold_addr_d = pend ? inst_sram_addr : hold_addr_q;
    fetch_pc_d = br_taken ? br_target : (hs & ~hold_q) ? fetch_pc_q + 32'd4 : fetch_pc_q;
  end
  // Fetch state registers
  always_ff @(posedge clk)
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      hold_q <= 1'b0;
      hold_addr_q <= '0;
      out_q <= '0;
      cancel_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      hold_q <= hold_d;
      hold_addr_q <= hold_addr_d;
      out_q <= out_d;
      cancel_q <= cancel_d;
    end
  // Bus protocol and credit invariants
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!inst_sram_data_ok || out_q != '0 || hs);
      assert (!(ibuf_push && ibuf_full && !ibuf_pop));
      assert (!(pcq_push && pcq_full));
      assert (32'(pcq_cnt) == 32'(out_q));
    end
endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb_if_stage_prefetch: directed scenarios against a latency-configurable instruction memory model
module tb_if_stage_prefetch;
  logic clk, reset;
  logic [32:0] br_bus;
  logic ID_allowin, IF_ID_valid;
  logic [63:0] IF_ID_bus;
  logic inst_sram_req, inst_sram_wr;
  logic [1:0] inst_sram_size;
  logic [3:0] inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic inst_sram_addr_ok, inst_sram_data_ok;
  typedef struct {
    logic [31:0] addr;
    int due;
  } rsp_t;
  rsp_t rq[$];
  logic [63:0] handed[$];
  int cyc, lat, checks, errors;
  bit aok;
  logic o_req, o_valid;
  logic [31:0] o_addr;
  logic [63:0] o_bus, got;

  if_stage_prefetch #(.RESET_PC(32'h1C00_0000), .IBUF_DEPTH(4), .MAX_OUTST(2)) dut (
    .clk(clk), .reset(reset), .br_bus(br_bus), .ID_allowin(ID_allowin),
    .IF_ID_valid(IF_ID_valid), .IF_ID_bus(IF_ID_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic cycle();
    logic dok;
    dok = !reset && rq.size() > 0 && rq[0].due <= cyc;
    inst_sram_addr_ok = aok & ~reset;
    inst_sram_data_ok = dok;
    inst_sram_rdata = dok ? ~rq[0].addr : 32'h0;
    #1;
    o_req = inst_sram_req;
    o_addr = inst_sram_addr;
    o_valid = IF_ID_valid;
    o_bus = IF_ID_bus;
    if (IF_ID_valid && ID_allowin) handed.push_back(IF_ID_bus);
    if (dok) rq.delete(0);
    if (inst_sram_req && inst_sram_addr_ok) rq.push_back('{inst_sram_addr, cyc + lat});
    if (reset) rq.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    br_bus = '0;
    cycle();
    cycle();
    reset = 1'b0;
    handed.delete();
  endtask

  task automatic wait_first(input logic [31:0] pc, input string name);
    for (int k = 0; k < 20 && handed.size() == 0; k++) cycle();
    got = handed.size() != 0 ? handed[0] : 64'bx;
    checks++;
    if (got !== ent(pc)) begin errors++; $display("FAIL %s got %h exp %h", name, got, ent(pc)); end
  endtask

  task automatic test_reset();
    reset = 1'b1; br_bus = '0; ID_allowin = 1'b1; aok = 1'b1; lat = 1;
    cycle();
    cycle();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", o_req); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_addr !== 32'h1C00_0000) begin errors++; $display("FAIL reset_addr got %h exp 1c000000", o_addr); end
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      errors++; $display("FAIL tieoffs got %b %b %h %h", inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    aok = 1'b1; lat = 1; ID_allowin = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) cycle();
    checks++; if (handed.size() != 6) begin errors++; $display("FAIL stream_count got %0d exp 6", handed.size()); end
    for (int i = 0; i < 6 && i < handed.size(); i++) begin
      checks++;
      if (handed[i] !== ent(32'h1C00_0000 + 32'(4 * i))) begin
        errors++; $display("FAIL stream_%0d got %h exp %h", i, handed[i], ent(32'h1C00_0000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    aok = 1'b1; lat = 1; ID_allowin = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) cycle();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", o_req); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", o_valid); end
    checks++; if (handed.size() != 0) begin errors++; $display("FAIL bp_stall got %0d exp 0", handed.size()); end
    ID_allowin = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    checks++; if (handed.size() != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", handed.size()); end
    for (int i = 0; i < 5 && i < handed.size(); i++) begin
      checks++;
      if (handed[i] !== ent(32'h1C00_0000 + 32'(4 * i))) begin
        errors++; $display("FAIL bp_%0d got %h exp %h", i, handed[i], ent(32'h1C00_0000 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_branch_flush();
    aok = 1'b1; lat = 3; ID_allowin = 1'b1;
    do_reset();
    cycle();
    cycle();
    br_bus = {1'b1, 32'h1C00_0100};
    cycle();
    br_bus = '0;
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL brf_full got %b exp 0", o_req); end
    cycle();
    checks++; if (o_addr !== 32'h1C00_0100) begin errors++; $display("FAIL brf_addr got %h exp 1c000100", o_addr); end
    wait_first(32'h1C00_0100, "brf_first");
  endtask

  task automatic test_hold_branch();
    aok = 1'b1; lat = 1; ID_allowin = 1'b1;
    do_reset();
    cycle();
    cycle();
    aok = 1'b0;
    cycle();
    checks++; if ({o_req, o_addr} !== {1'b1, 32'h1C00_0008}) begin errors++; $display("FAIL hold_pre got %b %h exp 1 1c000008", o_req, o_addr); end
    br_bus = {1'b1, 32'h1C00_0203};
    cycle();
    br_bus = '0;
    handed.delete();
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({o_req, o_addr} !== {1'b1, 32'h1C00_0008}) begin errors++; $display("FAIL hold_%0d got %b %h exp 1 1c000008", k, o_req, o_addr); end
    end
    aok = 1'b1;
    cycle();
    checks++; if (o_addr !== 32'h1C00_0008) begin errors++; $display("FAIL hold_accept got %h exp 1c000008", o_addr); end
    cycle();
    checks++; if ({o_req, o_addr} !== {1'b1, 32'h1C00_0200}) begin errors++; $display("FAIL hold_next got %b %h exp 1 1c000200", o_req, o_addr); end
    wait_first(32'h1C00_0200, "hold_first");
  endtask

  task automatic test_same_cycle();
    aok = 1'b1; lat = 1; ID_allowin = 1'b1;
    do_reset();
    cycle();
    cycle();
    cycle();
    br_bus = {1'b1, 32'h1C00_0300};
    cycle();
    br_bus = '0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b exp 0", o_valid); end
    checks++; if (handed.size() != 1) begin errors++; $display("FAIL same_handoffs got %0d exp 1", handed.size()); end
    handed.delete();
    cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL same_flush got %b exp 0", o_valid); end
    cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL same_cancel got %b exp 0", o_valid); end
    cycle();
    checks++; if ({o_valid, o_bus} !== {1'b1, ent(32'h1C00_0300)}) begin errors++; $display("FAIL same_next got %b %h exp 1 %h", o_valid, o_bus, ent(32'h1C00_0300)); end
  endtask

  task automatic test_back_to_back();
    aok = 1'b1; lat = 2; ID_allowin = 1'b1;
    do_reset();
    cycle();
    br_bus = {1'b1, 32'h1C00_0400};
    cycle();
    br_bus = {1'b1, 32'h1C00_0500};
    cycle();
    br_bus = '0;
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL b2b_req got %b exp 0", o_req); end
    cycle();
    checks++; if ({o_req, o_addr} !== {1'b1, 32'h1C00_0500}) begin errors++; $display("FAIL b2b_addr got %b %h exp 1 1c000500", o_req, o_addr); end
    wait_first(32'h1C00_0500, "b2b_first");
  endtask

  task automatic test_reset_mid();
    aok = 1'b1; lat = 3; ID_allowin = 1'b1;
    do_reset();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    checks++; if ({o_req, o_valid} !== 2'b00) begin errors++; $display("FAIL rmid_hold got %b %b exp 0 0", o_req, o_valid); end
    reset = 1'b0;
    cycle();
    checks++; if ({o_req, o_valid, o_addr} !== {2'b10, 32'h1C00_0000}) begin errors++; $display("FAIL rmid_restart got %b %b %h exp 1 0 1c000000", o_req, o_valid, o_addr); end
    wait_first(32'h1C00_0000, "rmid_first");
  endtask

  initial begin
    reset = 1'b1; br_bus = '0; ID_allowin = 1'b0; aok = 1'b0; lat = 1; cyc = 0; checks = 0; errors = 0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_hold_branch();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
